vec_dot_product_stream_loader: RTL and testbench
================================================

Name: vec_dot_product_stream_loader

Overview:
- Streaming front end for the 8-lane unsigned dot-product datapath.
- Accepts (a, b) element pairs one per handshake and assembles them into packed lane vectors (lane i = bits [i*EW +: EW]).
- Computes the dot product in a registered two-stage pipeline: multiply, then tree-add.
- Presents the result on a valid/ready output. It is the producer side that feeds the packed-vector dot-product interface from a serial source.

Parameters:
- N, 8, number of lanes per vector.
- EW, 8, element width in bits, unsigned.
- OUT_W, 2*EW+$clog2(N) (19 at defaults), result width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  element pair valid.
- in_ready  output  1  loader can accept an element pair.
- in_a  input  EW  element of vector a.
- in_b  input  EW  element of vector b.
- in_last  input  1  marks the final element of a vector; qualified by in_valid && in_ready.
- out_valid  output  1  dot_product is valid.
- out_ready  input  1  downstream accepts the result.
- dot_product  output  OUT_W  unsigned sum of lane products.
- out_short  output  1  vector closed by in_last before N elements; unfilled lanes counted as zero.
- busy  output  1  state != FILL, or at least one element accepted in the current vector.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = FILL, lane index = 0, all lane registers = 0.
  - out_valid = 0, dot_product = 0, out_short = 0, busy = 0.
  - in_ready = 1 once rst deasserts.
- Input handshake: a transfer occurs on a clock edge with in_valid && in_ready. in_ready = (state == FILL), decoded combinationally from the state register.
- Output handshake: a transfer occurs on a clock edge with out_valid && out_ready. Once asserted, out_valid stays high and dot_product/out_short stay stable until the transfer.
- States:
  - FILL:
    - Each transfer writes in_a/in_b into lane idx, then idx++.
    - Transfer with idx == N-1 or in_last: go to MUL. Latch short = in_last && idx != N-1.
  - MUL: register the N products (2*EW bits each, unsigned). Go to ADD.
  - ADD: register the tree sum (pairwise levels, widths growing by 1 bit per level) into dot_product. Drive out_short from the latched short. Go to HOLD.
  - HOLD:
    - out_valid = 1.
    - On output transfer: clear out_valid, clear all lanes to 0, set idx = 0, go to FILL.
    - in_ready rises in the cycle after the output transfer.
- Latency: final element accepted at edge T -> out_valid high after edge T+2. No input is accepted from edge T until FILL is re-entered.
- Arithmetic:
  - Fully unsigned. No truncation at any tree level.
  - Maximum result N*(2^EW-1)^2 = 520200 fits in OUT_W.
- Short vectors:
  - Lanes not written since the last clear are 0 and contribute 0.
  - in_last on the first element gives a single-product result.
- N-th element without in_last: the vector closes normally with out_short = 0. The next transfer starts a new vector.
- in_last on the N-th element: normal close, out_short = 0.
- in_a/in_b/in_last are don't-care when in_valid = 0 or in_ready = 0.
- Reset mid-operation (any state):
  - Partial vector and in-flight result are discarded.
  - Outputs return to reset values immediately (asynchronous).
  - No spurious out_valid after reset release.
- Throughput: one vector per (elements + 3 + output stall) cycles. No overlap of fill and compute.

Test Plan:
- Reset, no stimulus -> in_ready=1, out_valid=0, dot_product=0, busy=0. Assert rst mid-cycle -> outputs clear without a clock edge.
- Full vector a=1,2,...,8, b=2 for all lanes, out_ready=1 -> dot_product=72, out_short=0, out_valid exactly 2 edges after the 8th transfer and high for 1 cycle. in_ready=0 from the 8th transfer edge until the edge after the output transfer.
- All lanes a=b=0xFF -> dot_product=520200 (0x7F008), no overflow.
- Short vector a=(10,20,30), b=(1,2,3), in_last on the 3rd element -> dot_product=140, out_short=1. A following full vector of all ones -> 8, out_short=0 (stale lanes cleared).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid held high -> dot_product stable, in_ready=0, no element consumed. Release -> transfer, then in_ready=1 next cycle and back-to-back vectors produce correct results.
- Assert rst after 4 of 8 elements, then feed a full all-ones vector -> dot_product=8, out_short=0. Assert rst while in HOLD -> out_valid drops immediately, and the result is never transferred.

Source files
------------

// File: rtl/vec_dot_product_stream_loader.sv
// Serial (a, b) element loader feeding an N-lane unsigned dot product.
// Elements fill packed lanes, then a multiply stage and a tree-add stage produce a held result.
module vec_dot_product_stream_loader #(
  parameter int N  = 8,
  parameter int EW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EW-1:0]                in_a,
  input  logic [EW-1:0]                in_b,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*EW+$clog2(N)-1:0]    dot_product,
  output logic                         out_short,
  output logic                         busy
);

  localparam int OUT_W = 2*EW + $clog2(N);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {FILL, MUL, ADD, HOLD} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [EW-1:0]       a_p0 [N];
  logic [EW-1:0]       b_p0 [N];
  logic                short_p0;
  logic [2*EW-1:0]     prod_p1 [N];
  logic                last_lane;

  function automatic logic [2*EW-1:0] mul_u(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
  endfunction

  // Pairwise reduction; every level is held at full result width so nothing truncates.
  function automatic logic [OUT_W-1:0] tree_sum(input logic [2*EW-1:0] p [N]);
    logic [OUT_W-1:0] lvl [N];
    int w;
    for (int i = 0; i < N; i++) lvl[i] = OUT_W'(p[i]);
    w = N;
    for (int lv = 0; lv < IW; lv++) begin
      for (int i = 0; i < N/2; i++)
        if (i < w/2) lvl[i] = lvl[2*i] + lvl[2*i+1];
      if (w % 2 == 1) lvl[w/2] = lvl[w-1];
      w = (w + 1) / 2;
    end
    return lvl[0];
  endfunction

  assign in_ready  = (state == FILL);
  assign busy      = (state != FILL) || (idx != '0);
  assign last_lane = (idx == IW'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      idx         <= '0;
      short_p0    <= 1'b0;
      out_valid   <= 1'b0;
      out_short   <= 1'b0;
      dot_product <= '0;
      for (int i = 0; i < N; i++) begin
        a_p0[i]    <= '0;
        b_p0[i]    <= '0;
        prod_p1[i] <= '0;
      end
    end else begin
      case (state)
        // Stage p0: lane assembly
        FILL: begin
          if (in_valid) begin
            a_p0[idx] <= in_a;
            b_p0[idx] <= in_b;
            idx       <= idx + 1'b1;
            if (last_lane || in_last) begin
              idx      <= '0;
              short_p0 <= in_last && !last_lane;
              state    <= MUL;
            end
          end
        end
        // Stage p1: lane products
        MUL: begin
          for (int i = 0; i < N; i++) prod_p1[i] <= mul_u(a_p0[i], b_p0[i]);
          state <= ADD;
        end
        // Stage p2: tree sum into the output register
        ADD: begin
          dot_product <= tree_sum(prod_p1);
          out_short   <= short_p0;
          out_valid   <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            for (int i = 0; i < N; i++) begin
              a_p0[i] <= '0;
              b_p0[i] <= '0;
            end
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_product_stream_loader.sv
// Directed bench for the dot-product stream loader: timing, arithmetic, short vectors,
// backpressure and asynchronous reset.
module tb_vec_dot_product_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] dot_product;
  logic        out_short;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_dot_product_stream_loader #(.N(8), .EW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .dot_product(dot_product), .out_short(out_short), .busy(busy)
  );

  always #5 clk = ~clk;

  // Feeds n elements, then waits for out_valid; completes the output transfer if out_ready is high.
  task automatic run_vector(input logic [63:0] va, input logic [63:0] vb, input int n,
                            input bit last_final, output logic [18:0] dot,
                            output logic sh, output bit ok);
    int w;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!in_ready && w < 30) begin @(negedge clk); w++; end
      if (!in_ready) ok = 1'b0;
      in_valid = 1'b1;
      in_a     = va[i*8 +: 8];
      in_b     = vb[i*8 +: 8];
      in_last  = last_final && (i == n-1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    w = 0;
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    if (!out_valid) ok = 1'b0;
    dot = dot_product;
    sh  = out_short;
    if (out_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (dot_product !== 19'd0) begin n_fail++; $display("FAIL rst_dot got=%0d exp=0", dot_product); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_short !== 1'b0) begin n_fail++; $display("FAIL rel_out_short got=%b exp=0", out_short); end
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL partial_busy got=%b exp=1", busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got=%b exp=0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_timing();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 8'(i + 1); in_b = 8'd2; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t0_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t0_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t0_busy got=%b exp=1", busy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t2_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (dot_product !== 19'd72) begin n_fail++; $display("FAIL full_dot got=%0d exp=72", dot_product); end
    n_cmp++; if (out_short !== 1'b0) begin n_fail++; $display("FAIL full_short got=%b exp=0", out_short); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t2_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t3_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy got=%b exp=0", busy); end
  endtask

  task automatic test_max();
    logic [18:0] d; logic s; bit ok;
    run_vector({8{8'hFF}}, {8{8'hFF}}, 8, 1'b0, d, s, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL max_timeout got=%b exp=1", ok); end
    n_cmp++; if (d !== 19'd520200) begin n_fail++; $display("FAIL max_dot got=%0d exp=520200", d); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL max_short got=%b exp=0", s); end
  endtask

  task automatic test_short();
    logic [18:0] d; logic s; bit ok;
    run_vector(64'h1E140A, 64'h030201, 3, 1'b1, d, s, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL short_timeout got=%b exp=1", ok); end
    n_cmp++; if (d !== 19'd140) begin n_fail++; $display("FAIL short_dot got=%0d exp=140", d); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL short_flag got=%b exp=1", s); end
    run_vector({8{8'h01}}, {8{8'h01}}, 8, 1'b0, d, s, ok);
    n_cmp++; if (d !== 19'd8 || ok !== 1'b1) begin n_fail++; $display("FAIL ones_dot got=%0d exp=8", d); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL ones_short got=%b exp=0", s); end
  endtask

  task automatic test_nth_last();
    logic [18:0] d; logic s; bit ok;
    run_vector(64'h0807060504030201, 64'h0908070605040302, 8, 1'b1, d, s, ok);
    n_cmp++; if (d !== 19'd240 || ok !== 1'b1) begin n_fail++; $display("FAIL nth_dot got=%0d exp=240", d); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL nth_short got=%b exp=0", s); end
  endtask

  task automatic test_backpressure();
    logic [18:0] d; logic s; bit ok; int bad;
    out_ready = 1'b0;
    run_vector(64'h0807060504030201, {8{8'h01}}, 8, 1'b0, d, s, ok);
    n_cmp++; if (d !== 19'd36 || ok !== 1'b1) begin n_fail++; $display("FAIL bp_dot got=%0d exp=36", d); end
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99; in_last = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || dot_product !== 19'd36 || in_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rel_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_in_ready got=%b exp=1", in_ready); end
    run_vector(64'h07, 64'h09, 1, 1'b1, d, s, ok);
    n_cmp++; if (d !== 19'd63 || ok !== 1'b1) begin n_fail++; $display("FAIL b2b1_dot got=%0d exp=63", d); end
    n_cmp++; if (s !== 1'b1) begin n_fail++; $display("FAIL b2b1_short got=%b exp=1", s); end
    run_vector(64'h0807060504030201, 64'h0807060504030201, 8, 1'b0, d, s, ok);
    n_cmp++; if (d !== 19'd204 || ok !== 1'b1) begin n_fail++; $display("FAIL b2b2_dot got=%0d exp=204", d); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL b2b2_short got=%b exp=0", s); end
  endtask

  task automatic test_reset_mid();
    logic [18:0] d; logic s; bit ok; int bad;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vector({8{8'h01}}, {8{8'h01}}, 8, 1'b0, d, s, ok);
    n_cmp++; if (d !== 19'd8 || ok !== 1'b1) begin n_fail++; $display("FAIL rmid_dot got=%0d exp=8", d); end
    n_cmp++; if (s !== 1'b0) begin n_fail++; $display("FAIL rmid_short got=%b exp=0", s); end
    out_ready = 1'b0;
    run_vector({8{8'h02}}, {8{8'h03}}, 8, 1'b0, d, s, ok);
    n_cmp++; if (d !== 19'd48 || ok !== 1'b1) begin n_fail++; $display("FAIL hold_dot got=%0d exp=48", d); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_rst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (dot_product !== 19'd0) begin n_fail++; $display("FAIL hold_rst_dot got=%0d exp=0", dot_product); end
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL post_rst_idle bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_full_timing();
    test_max();
    test_short();
    test_nth_last();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
